// File: rtl/exp_align_scheduler_pkg.sv
// Shared defaults, FSM state type and shift clamp for exp_align_scheduler.
package exp_align_pkg;

    localparam int unsigned EXP_W_DEF     = 5;
    localparam int unsigned N_TERMS_DEF   = 9;
    localparam int unsigned MAX_SHIFT_DEF = 15;

    typedef enum logic {COLLECT, EMIT} state_t;

    // Caller guarantees max_e >= exp_e, so the difference never wraps.
    function automatic int unsigned sat_shift(input int unsigned max_e,
                                              input int unsigned exp_e,
                                              input int unsigned limit);
        int unsigned diff;
        diff = max_e - exp_e;
        return (diff > limit) ? limit : diff;
    endfunction

endpackage

// File: rtl/exp_align_scheduler_max_tracker.sv
// Running group maximum: loads on the first accept, compares on the rest.
// Zero exponents are excluded when EXP_ALIGN_ZERO_SKIP_EN is defined.
module exp_max_tracker
    import exp_align_pkg::*;
#(
    parameter int unsigned EXP_W = EXP_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             accept,
    input  logic             first,
    input  logic [EXP_W-1:0] exp_in,
    output logic [EXP_W-1:0] max_r
);

    logic take;

`ifdef EXP_ALIGN_ZERO_SKIP_EN
    assign take = (exp_in != '0);
`else
    assign take = 1'b1;
`endif

    // A zero loaded on first accept acts as "no maximum yet" under zero-skip.
    always_ff @(posedge clk) begin
        if (rst) begin
            max_r <= '0;
        end else if (accept) begin
            if (first) begin
                max_r <= exp_in;
            end else if (take && (exp_in > max_r)) begin
                max_r <= exp_in;
            end
        end
    end

endmodule

// File: rtl/exp_align_scheduler.sv
// Streaming exponent-alignment scheduler: collect N_TERMS exponents, then emit
// per-term saturated right-shifts in order. Optional: EXP_ALIGN_ZERO_SKIP_EN.
module exp_align_scheduler
    import exp_align_pkg::*;
#(
    parameter int unsigned EXP_W     = EXP_W_DEF,
    parameter int unsigned N_TERMS   = N_TERMS_DEF,
    parameter int unsigned MAX_SHIFT = MAX_SHIFT_DEF,
    parameter int unsigned SHIFT_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [EXP_W-1:0]   in_exp,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SHIFT_W-1:0] out_shift,
    output logic               out_zero,
    output logic               out_last,
    output logic [EXP_W-1:0]   out_exp_max
);

    localparam int unsigned IDX_W = $clog2(N_TERMS);

    state_t             state, state_nxt;
    logic [EXP_W-1:0]   exp_buf [N_TERMS];
    logic [IDX_W-1:0]   wr_idx, rd_idx;
    logic [EXP_W-1:0]   max_r;
    logic [EXP_W-1:0]   rd_exp;
    logic               in_accept, out_accept, wr_last, rd_last, rd_zero;

    assign in_accept  = in_valid & in_ready;
    assign out_accept = out_valid & out_ready;
    assign wr_last    = (wr_idx == IDX_W'(N_TERMS - 1));
    assign rd_last    = (rd_idx == IDX_W'(N_TERMS - 1));

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            COLLECT: begin
                in_ready = 1'b1;
                if (in_valid && wr_last) state_nxt = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready && rd_last) state_nxt = COLLECT;
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= COLLECT;
            wr_idx <= '0;
            rd_idx <= '0;
        end else begin
            state <= state_nxt;
            if (in_accept) wr_idx <= wr_last ? '0 : wr_idx + 1'b1;
            if (out_accept) rd_idx <= rd_last ? '0 : rd_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (in_accept) exp_buf[wr_idx] <= in_exp;
    end

    exp_max_tracker #(.EXP_W(EXP_W)) u_max (
        .clk    (clk),
        .rst    (rst),
        .accept (in_accept),
        .first  (wr_idx == '0),
        .exp_in (in_exp),
        .max_r  (max_r)
    );

`ifdef EXP_ALIGN_ZERO_SKIP_EN
    logic zflag [N_TERMS];

    always_ff @(posedge clk) begin
        if (in_accept) zflag[wr_idx] <= (in_exp == '0);
    end

    assign rd_zero = zflag[rd_idx];
`else
    assign rd_zero = 1'b0;
`endif

    assign rd_exp = exp_buf[rd_idx];

    // Outputs are gated by state so they read zero outside EMIT.
    always_comb begin
        out_shift = '0;
        out_zero  = 1'b0;
        out_last  = 1'b0;
        if (out_valid) begin
            out_zero  = rd_zero;
            out_last  = rd_last;
            out_shift = rd_zero ? SHIFT_W'(MAX_SHIFT)
                                : SHIFT_W'(sat_shift(32'(max_r), 32'(rd_exp), MAX_SHIFT));
        end
    end

    assign out_exp_max = max_r;

endmodule

// File: tb/tb_exp_align_scheduler.sv
// Scoreboard bench for exp_align_scheduler (default parameters).
module tb_exp_align_scheduler;

    localparam int TIMEOUT = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] in_exp = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [4:0] out_shift;
    logic       out_zero;
    logic       out_last;
    logic [4:0] out_exp_max;

    typedef struct {int shift; int last; int zero; int emax;} rec_t;

    rec_t sb[$];
    rec_t obs[$];
    int   tests = 0;
    int   failed = 0;
    int   cyc = 0;
    int   stall_viol = 0;
    int   ready_viol = 0;
    int   pre_last_valid = 0;

    exp_align_scheduler #(.EXP_W(5), .N_TERMS(9), .MAX_SHIFT(15), .SHIFT_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_exp      (in_exp),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_shift   (out_shift),
        .out_zero    (out_zero),
        .out_last    (out_last),
        .out_exp_max (out_exp_max)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push_expected(input int e[9]);
        int mx;
        rec_t r;
        mx = 0;
        for (int i = 0; i < 9; i++) if (e[i] > mx) mx = e[i];
        for (int i = 0; i < 9; i++) begin
`ifdef EXP_ALIGN_ZERO_SKIP_EN
            r.zero = (e[i] == 0) ? 1 : 0;
`else
            r.zero = 0;
`endif
            r.shift = r.zero ? 15 : (((mx - e[i]) > 15) ? 15 : (mx - e[i]));
            r.last  = (i == 8) ? 1 : 0;
            r.emax  = mx;
            sb.push_back(r);
        end
    endfunction

    task automatic send_terms(input int e[9], input int n, input bit keep_valid,
                              output int first_edge);
        int waited;
        bit done;
        first_edge = -1;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_exp   = 5'(e[i]);
            waited   = 0;
            done     = 1'b0;
            while (!done) begin
                @(negedge clk);
                if (i == n - 1) pre_last_valid = int'(out_valid);
                if (in_ready) begin
                    if (i == 0) first_edge = cyc + 1;
                    done = 1'b1;
                end else if (++waited > TIMEOUT) begin
                    tests++; failed++;
                    $display("FAIL send_timeout: term %0d not accepted within %0d cycles", i, TIMEOUT);
                    done = 1'b1;
                end
                @(posedge clk); #1;
            end
        end
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic recv(input int n, input bit rand_stall, output int last_edge);
        int   got, cycles;
        bit   held;
        rec_t cur, prev;
        got = 0; cycles = 0; held = 1'b0; last_edge = -1;
        prev = '{0, 0, 0, 0};
        while (got < n) begin
            out_ready = rand_stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            @(negedge clk);
            if (out_valid) begin
                cur.shift = int'(out_shift);
                cur.last  = int'(out_last);
                cur.zero  = int'(out_zero);
                cur.emax  = int'(out_exp_max);
                if (held && (cur.shift != prev.shift || cur.last != prev.last ||
                             cur.zero != prev.zero || cur.emax != prev.emax)) stall_viol++;
                if (in_ready) ready_viol++;
                if (out_ready) begin
                    obs.push_back(cur);
                    got++;
                    if (cur.last == 1 && last_edge < 0) last_edge = cyc + 1;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    prev = cur;
                end
            end
            if (++cycles > TIMEOUT) begin
                tests++; failed++;
                $display("FAIL recv_timeout: got %0d of %0d outputs", got, n);
                break;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests++; if (out_shift !== 5'd0) begin failed++; $display("FAIL reset_out_shift: got %0d want 0", out_shift); end
        tests++; if (out_zero !== 1'b0) begin failed++; $display("FAIL reset_out_zero: got %b want 0", out_zero); end
        tests++; if (out_last !== 1'b0) begin failed++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        tests++; if (out_exp_max !== 5'd0) begin failed++; $display("FAIL reset_exp_max: got %0d want 0", out_exp_max); end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int g[9] = '{3, 7, 1, 7, 0, 2, 5, 6, 4};
        int fe, le;
        rec_t o, x;
        push_expected(g);
        send_terms(g, 9, 1'b0, fe);
        tests++; if (pre_last_valid !== 0) begin failed++; $display("FAIL basic_valid_early: got %0d want 0", pre_last_valid); end
        tests++; if (out_valid !== 1'b1) begin failed++; $display("FAIL basic_valid_latency: got %b want 1", out_valid); end
        tests++; if (out_exp_max !== 5'd7) begin failed++; $display("FAIL basic_exp_max: got %0d want 7", out_exp_max); end
        recv(9, 1'b0, le);
        while (obs.size() > 0) begin
            o = obs.pop_front();
            x = sb.pop_front();
            tests++;
            if (o.shift !== x.shift || o.last !== x.last || o.zero !== x.zero || o.emax !== x.emax) begin
                failed++;
                $display("FAIL basic_out: got shift=%0d last=%0d zero=%0d emax=%0d want shift=%0d last=%0d zero=%0d emax=%0d",
                         o.shift, o.last, o.zero, o.emax, x.shift, x.last, x.zero, x.emax);
            end
        end
    endtask

    task automatic test_spread;
        int g[9] = '{30, 1, 1, 1, 1, 1, 1, 1, 1};
        int fe, le;
        rec_t o, x;
        push_expected(g);
        send_terms(g, 9, 1'b0, fe);
        recv(9, 1'b0, le);
        while (obs.size() > 0) begin
            o = obs.pop_front();
            x = sb.pop_front();
            tests++;
            if (o.shift !== x.shift || o.last !== x.last || o.zero !== x.zero || o.emax !== x.emax) begin
                failed++;
                $display("FAIL spread_out: got shift=%0d last=%0d emax=%0d want shift=%0d last=%0d emax=%0d",
                         o.shift, o.last, o.emax, x.shift, x.last, x.emax);
            end
        end
    endtask

    task automatic test_backpressure;
        int g[9] = '{10, 3, 12, 0, 12, 5, 9, 1, 7};
        int fe, le;
        rec_t o, x;
        stall_viol = 0;
        ready_viol = 0;
        push_expected(g);
        send_terms(g, 9, 1'b0, fe);
        recv(9, 1'b1, le);
        tests++; if (obs.size() != 9) begin failed++; $display("FAIL bp_count: got %0d want 9", obs.size()); end
        while (obs.size() > 0) begin
            o = obs.pop_front();
            x = sb.pop_front();
            tests++;
            if (o.shift !== x.shift || o.last !== x.last || o.zero !== x.zero || o.emax !== x.emax) begin
                failed++;
                $display("FAIL bp_out: got shift=%0d last=%0d emax=%0d want shift=%0d last=%0d emax=%0d",
                         o.shift, o.last, o.emax, x.shift, x.last, x.emax);
            end
        end
        tests++; if (stall_viol != 0) begin failed++; $display("FAIL bp_stable: got %0d changes want 0", stall_viol); end
        tests++; if (ready_viol != 0) begin failed++; $display("FAIL bp_in_ready: got %0d high cycles want 0", ready_viol); end
    endtask

    task automatic test_reset_mid;
        int junk[9] = '{31, 31, 31, 31, 31, 0, 0, 0, 0};
        int g[9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        int fe, le;
        rec_t o, x;
        send_terms(junk, 5, 1'b0, fe);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        tests++; if (out_exp_max !== 5'd0) begin failed++; $display("FAIL midrst_exp_max: got %0d want 0", out_exp_max); end
        push_expected(g);
        send_terms(g, 9, 1'b0, fe);
        recv(9, 1'b0, le);
        while (obs.size() > 0) begin
            o = obs.pop_front();
            x = sb.pop_front();
            tests++;
            if (o.shift !== x.shift || o.last !== x.last || o.zero !== x.zero || o.emax !== x.emax) begin
                failed++;
                $display("FAIL midrst_out: got shift=%0d last=%0d emax=%0d want shift=%0d last=%0d emax=%0d",
                         o.shift, o.last, o.emax, x.shift, x.last, x.emax);
            end
        end
    endtask

`ifdef EXP_ALIGN_ZERO_SKIP_EN
    task automatic test_zero_skip;
        int g1[9] = '{0, 4, 0, 2, 0, 0, 0, 0, 1};
        int g2[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        int fe, le;
        rec_t o, x;
        push_expected(g1);
        send_terms(g1, 9, 1'b0, fe);
        recv(9, 1'b0, le);
        push_expected(g2);
        send_terms(g2, 9, 1'b0, fe);
        recv(9, 1'b0, le);
        while (obs.size() > 0) begin
            o = obs.pop_front();
            x = sb.pop_front();
            tests++;
            if (o.shift !== x.shift || o.last !== x.last || o.zero !== x.zero || o.emax !== x.emax) begin
                failed++;
                $display("FAIL zero_out: got shift=%0d last=%0d zero=%0d emax=%0d want shift=%0d last=%0d zero=%0d emax=%0d",
                         o.shift, o.last, o.zero, o.emax, x.shift, x.last, x.zero, x.emax);
            end
        end
    endtask
`endif

    task automatic test_back_to_back;
        int g1[9] = '{9, 14, 3, 8, 20, 6, 11, 2, 5};
        int g2[9] = '{2, 2, 2, 2, 2, 2, 2, 2, 2};
        int fe1, fe2, le;
        rec_t o, x;
        push_expected(g1);
        push_expected(g2);
        fork
            begin
                send_terms(g1, 9, 1'b1, fe1);
                send_terms(g2, 9, 1'b0, fe2);
            end
            recv(18, 1'b0, le);
        join
        tests++;
        if (fe2 !== le + 1) begin
            failed++;
            $display("FAIL b2b_no_bubble: got accept edge %0d want %0d", fe2, le + 1);
        end
        tests++; if (out_exp_max !== 5'd2) begin failed++; $display("FAIL b2b_reload: got %0d want 2", out_exp_max); end
        while (obs.size() > 0) begin
            o = obs.pop_front();
            x = sb.pop_front();
            tests++;
            if (o.shift !== x.shift || o.last !== x.last || o.zero !== x.zero || o.emax !== x.emax) begin
                failed++;
                $display("FAIL b2b_out: got shift=%0d last=%0d emax=%0d want shift=%0d last=%0d emax=%0d",
                         o.shift, o.last, o.emax, x.shift, x.last, x.emax);
            end
        end
        tests++; if (sb.size() != 0) begin failed++; $display("FAIL sb_drained: got %0d left want 0", sb.size()); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_spread;
        test_backpressure;
        test_reset_mid;
`ifdef EXP_ALIGN_ZERO_SKIP_EN
        test_zero_skip;
`endif
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
